// File: rtl/sindoku_pkg.sv
// Shared constants for the Sudoku board display: board size, game status
// encodings, glyph codes and active-low seven-segment patterns {g..a}.
package sindoku_pkg;

   localparam int BOARD_DIM = 9;

   localparam logic [4:0] ST_I         = 5'b00001;
   localparam logic [4:0] ST_SOLVE     = 5'b00010;
   localparam logic [4:0] ST_CHECK     = 5'b00100;
   localparam logic [4:0] ST_CORRECT   = 5'b01000;
   localparam logic [4:0] ST_INCORRECT = 5'b10000;

   // Digit glyphs occupy codes 0..9 so a cell value maps straight onto its glyph.
   typedef enum logic [4:0] {
      G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
      G_R, G_LC, G_I, G_S, G_UC, G_P, G_F, G_DASH, G_UNDER, G_E, G_BLANK
   } glyph_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_LC    = 7'h27;
   localparam logic [6:0] SEG_I     = 7'h4F;
   localparam logic [6:0] SEG_S     = 7'h12;
   localparam logic [6:0] SEG_UC    = 7'h46;
   localparam logic [6:0] SEG_P     = 7'h0C;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_UNDER = 7'h77;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic glyph_t digit_glyph(input logic [3:0] v);
      return glyph_t'({1'b0, v});
   endfunction

   function automatic logic [6:0] cell_addr(input logic [3:0] r, input logic [3:0] c);
      return 7'(r) * 7'(BOARD_DIM) + 7'(c);
   endfunction

endpackage

// File: rtl/sindoku_glyph.sv
// Glyph code to active-low seven-segment pattern decoder.
module sindoku_glyph
   import sindoku_pkg::*;
(
   input  glyph_t     glyph,
   output logic [6:0] seg
);

   // Pure lookup; unknown codes fall back to a dark digit.
   always_comb begin
      seg = SEG_BLANK;
      case (glyph)
         G_0:     seg = SEG_0;
         G_1:     seg = SEG_1;
         G_2:     seg = SEG_2;
         G_3:     seg = SEG_3;
         G_4:     seg = SEG_4;
         G_5:     seg = SEG_5;
         G_6:     seg = SEG_6;
         G_7:     seg = SEG_7;
         G_8:     seg = SEG_8;
         G_9:     seg = SEG_9;
         G_R:     seg = SEG_R;
         G_LC:    seg = SEG_LC;
         G_I:     seg = SEG_I;
         G_S:     seg = SEG_S;
         G_UC:    seg = SEG_UC;
         G_P:     seg = SEG_P;
         G_F:     seg = SEG_F;
         G_DASH:  seg = SEG_DASH;
         G_UNDER: seg = SEG_UNDER;
         G_E:     seg = SEG_E;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sindoku_board_display.sv
// Multiplexed seven-segment view of the cursor cell: refresh/digit scan,
// one board read per frame, blink timing for empty cells in SOLVE.
//
// state  | meaning
// IDLE   | waiting for frame start
// REQ    | read strobe asserted with the cursor cell address
// WAIT   | counting read latency, data latched on the last cycle
module sindoku_board_display
   import sindoku_pkg::*;
#(
   parameter int DIGIT_PERIOD = 100000,
   parameter int BLINK_FRAMES = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] row,
   input  logic [3:0] col,
   input  logic [4:0] status,
   output logic       cell_rd_en,
   output logic [6:0] cell_rd_addr,
   input  logic [3:0] cell_rd_data,
   output logic [7:0] An,
   output logic [6:0] Ssd,
   output logic       Dp
);

   localparam int RW = $clog2(DIGIT_PERIOD);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(DIGIT_PERIOD - 1);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_FRAMES - 1);
   localparam logic          LAT_LAST     = 1'(READ_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} rd_state_t;

   rd_state_t       state, state_nxt;
   logic [RW-1:0]   refresh_cnt;
   logic [2:0]      dig_idx;
   logic [BW-1:0]   blink_cnt;
   logic            blink_on;
   logic            display_on;
   logic [3:0]      row_s, col_s;
   logic [3:0]      value;
   logic            invalid;
   logic            lat_cnt;
   logic            latch;
   logic            frame_start;
   logic            cursor_ok;
   glyph_t          glyph_sel;
   logic [6:0]      seg_nxt;

   assign frame_start = (refresh_cnt == REFRESH_LAST) && (dig_idx == 3'd7);
   assign cursor_ok   = (row <= 4'd8) && (col <= 4'd8);
   assign Dp          = 1'b1;

   // Per-digit dwell counter and digit scan index.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         refresh_cnt <= '0;
         dig_idx     <= '0;
      end else if (refresh_cnt == REFRESH_LAST) begin
         refresh_cnt <= '0;
         dig_idx     <= dig_idx + 3'd1;
      end else begin
         refresh_cnt <= refresh_cnt + RW'(1);
      end
   end

   // Frame-rate bookkeeping: cursor snapshot, blink timing, display enable.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         row_s      <= '0;
         col_s      <= '0;
         blink_cnt  <= '0;
         blink_on   <= 1'b1;
         display_on <= 1'b0;
      end else if (frame_start) begin
         row_s      <= row;
         col_s      <= col;
         display_on <= 1'b1;
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Read FSM next state and strobe decode.
   always_comb begin
      state_nxt  = state;
      cell_rd_en = 1'b0;
      latch      = 1'b0;
      case (state)
         S_IDLE: if (frame_start && cursor_ok) state_nxt = S_REQ;
         S_REQ: begin
            cell_rd_en = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: if (lat_cnt == LAT_LAST) begin
            latch     = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Read address, latency counter, latched cell value and invalid flag.
   // The address is loaded from the live cursor at frame start, which is the
   // same value row_s/col_s capture on that edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cell_rd_addr <= '0;
         lat_cnt      <= 1'b0;
         value        <= '0;
         invalid      <= 1'b0;
      end else begin
         lat_cnt <= (state == S_WAIT) ? lat_cnt + 1'b1 : 1'b0;
         if (state == S_IDLE && frame_start) begin
            if (cursor_ok) cell_rd_addr <= cell_addr(row, col);
            else           invalid      <= 1'b1;
         end
         if (latch) begin
            value   <= cell_rd_data;
            invalid <= 1'b0;
         end
      end
   end

   // Glyph selection for the digit currently being scanned.
   always_comb begin
      glyph_sel = G_BLANK;
      case (dig_idx)
         3'd7: glyph_sel = G_R;
         3'd6: glyph_sel = (row_s > 4'd8) ? G_DASH : digit_glyph(row_s + 4'd1);
         3'd5: glyph_sel = G_LC;
         3'd4: glyph_sel = (col_s > 4'd8) ? G_DASH : digit_glyph(col_s + 4'd1);
         3'd2: begin
            if (invalid)              glyph_sel = G_DASH;
            else if (value > 4'd9)    glyph_sel = G_E;
            else if (value == 4'd0)   glyph_sel = (status == ST_SOLVE && !blink_on) ? G_BLANK : G_UNDER;
            else                      glyph_sel = digit_glyph(value);
         end
         3'd0: begin
            case (status)
               ST_I:         glyph_sel = G_I;
               ST_SOLVE:     glyph_sel = G_S;
               ST_CHECK:     glyph_sel = G_UC;
               ST_CORRECT:   glyph_sel = G_P;
               ST_INCORRECT: glyph_sel = G_F;
               default:      glyph_sel = G_DASH;
            endcase
         end
         default: glyph_sel = G_BLANK;
      endcase
   end

   sindoku_glyph u_glyph (
      .glyph (glyph_sel),
      .seg   (seg_nxt)
   );

   // Anode and segment registers move together; dark until the first frame.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         An  <= 8'hFF;
         Ssd <= 7'h7F;
      end else if (display_on) begin
         An  <= ~(8'd1 << dig_idx);
         Ssd <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_sindoku_board_display.sv
// Bench for sindoku_board_display: two instances (read latency 1 and 2) share
// cursor/status inputs; each has its own board-memory responder.
module tb_sindoku_board_display;

   localparam int DP = 4;
   localparam int BF = 2;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [3:0] row, col;
   logic [4:0] status;
   logic       en_a, en_b;
   logic [6:0] addr_a, addr_b;
   logic [3:0] data_a, data_b;
   logic [7:0] an_a, an_b;
   logic [6:0] ssd_a, ssd_b;
   logic       dp_a, dp_b;

   logic [3:0] board [0:80];
   logic [3:0] junk_b;
   logic [3:0] stage_b;

   int vectors = 0;
   int miscompares = 0;
   int frames;
   int rd_pulses_a, rd_pulses_b;
   logic [6:0] last_addr_a, last_addr_b;
   logic [7:0] an_prev;

   always #5 Clk = ~Clk;

   sindoku_board_display #(.DIGIT_PERIOD(DP), .BLINK_FRAMES(BF), .READ_LATENCY(1)) dut_a (
      .Clk(Clk), .Reset(Reset), .row(row), .col(col), .status(status),
      .cell_rd_en(en_a), .cell_rd_addr(addr_a), .cell_rd_data(data_a),
      .An(an_a), .Ssd(ssd_a), .Dp(dp_a));

   sindoku_board_display #(.DIGIT_PERIOD(DP), .BLINK_FRAMES(BF), .READ_LATENCY(2)) dut_b (
      .Clk(Clk), .Reset(Reset), .row(row), .col(col), .status(status),
      .cell_rd_en(en_b), .cell_rd_addr(addr_b), .cell_rd_data(data_b),
      .An(an_b), .Ssd(ssd_b), .Dp(dp_b));

   // Board memories: data valid exactly 1 (a) or 2 (b) cycles after the strobe,
   // junk on every other cycle.
   always @(posedge Clk) begin
      data_a  <= en_a ? board[addr_a] : 4'($urandom);
      stage_b <= en_b ? board[addr_b] : junk_b;
      data_b  <= stage_b;
   end

   // Observers: frame count since reset, read strobes and their addresses.
   always @(negedge Clk or posedge Reset) begin
      if (Reset) begin
         frames      <= 0;
         an_prev     <= 8'hFF;
         rd_pulses_a <= 0;
         rd_pulses_b <= 0;
         last_addr_a <= '0;
         last_addr_b <= '0;
      end else begin
         an_prev <= an_a;
         if (an_a == 8'hFE && an_prev != 8'hFE) frames <= frames + 1;
         if (en_a) begin rd_pulses_a <= rd_pulses_a + 1; last_addr_a <= addr_a; end
         if (en_b) begin rd_pulses_b <= rd_pulses_b + 1; last_addr_b <= addr_b; end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [6:0] seg_of(input byte ch);
      string lit;
      logic [6:0] on;
      case (ch)
         "0": lit = "abcdef";
         "1": lit = "bc";
         "2": lit = "abdeg";
         "3": lit = "abcdg";
         "4": lit = "bcfg";
         "5": lit = "acdfg";
         "6": lit = "acdefg";
         "7": lit = "abc";
         "8": lit = "abcdefg";
         "9": lit = "abcdfg";
         "r": lit = "eg";
         "c": lit = "deg";
         "I": lit = "ef";
         "S": lit = "acdfg";
         "C": lit = "adef";
         "P": lit = "abefg";
         "F": lit = "aefg";
         "-": lit = "g";
         "_": lit = "d";
         "E": lit = "adefg";
         default: lit = "";
      endcase
      on = '0;
      for (int i = 0; i < lit.len(); i++) on[int'(lit[i]) - 97] = 1'b1;
      return ~on;
   endfunction

   function automatic byte exp_char(input int d, input logic [3:0] r, input logic [3:0] c,
                                    input logic [4:0] st, input logic [3:0] v, input bit ph);
      byte ch;
      ch = " ";
      case (d)
         7: ch = "r";
         6: ch = (r > 8) ? "-" : byte'(48 + int'(r) + 1);
         5: ch = "c";
         4: ch = (c > 8) ? "-" : byte'(48 + int'(c) + 1);
         2: begin
            if (r > 8 || c > 8) ch = "-";
            else if (v > 9)     ch = "E";
            else if (v == 0)    ch = (st == 5'b00010 && !ph) ? " " : "_";
            else                ch = byte'(48 + int'(v));
         end
         0: begin
            if ($countones(st) != 1) ch = "-";
            else if (st[0]) ch = "I";
            else if (st[1]) ch = "S";
            else if (st[2]) ch = "C";
            else if (st[3]) ch = "P";
            else            ch = "F";
         end
         default: ch = " ";
      endcase
      return ch;
   endfunction

   task automatic wait_an(input logic [7:0] target, input string name);
      int n;
      n = 0;
      do begin
         @(negedge Clk); #1;
         n++;
      end while (an_a !== target && n < 200);
      if (an_a !== target) begin
         vectors++; miscompares++;
         $display("FAIL %s: timeout waiting for An=%h, last An=%h", name, target, an_a);
      end
   endtask

   task automatic check_quiet(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk); #1;
         vectors++;
         if ({an_a, ssd_a, dp_a, en_a, addr_a, an_b, ssd_b, dp_b, en_b, addr_b} !==
             {8'hFF, 7'h7F, 1'b1, 1'b0, 7'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 7'd0}) begin
            miscompares++;
            $display("FAIL %s cycle %0d: An=%h/%h Ssd=%h/%h Dp=%b/%b en=%b/%b addr=%0d/%0d, required FF 7F 1 0 0",
                     name, i, an_a, an_b, ssd_a, ssd_b, dp_a, dp_b, en_a, en_b, addr_a, addr_b);
         end
      end
   endtask

   // Apply a cursor/status mid-frame, then check the whole next frame.
   task automatic check_frame(input string name, input logic [3:0] r, input logic [3:0] c,
                              input logic [4:0] st);
      int pa, pb;
      bit ph, ok;
      logic [3:0] v;
      logic [6:0] exp;
      logic [7:0] mask;
      byte ch;
      wait_an(8'hFD, name);
      row = r; col = c; status = st;
      pa = rd_pulses_a; pb = rd_pulses_b;
      wait_an(8'hFE, name);
      ph = ((frames / BF) % 2) == 0;
      ok = (r <= 8) && (c <= 8);
      v  = ok ? board[int'(r) * 9 + int'(c)] : 4'd0;
      for (int d = 0; d < 8; d++) begin
         mask = ~(8'd1 << d);
         if (d > 0) wait_an(mask, name);
         ch  = exp_char(d, r, c, st, v, ph);
         exp = seg_of(ch);
         vectors++;
         if (ssd_a !== exp) begin
            miscompares++;
            $display("FAIL %s d%0d lat1: Ssd=%h required %h ('%c')", name, d, ssd_a, exp, ch);
         end
         vectors++;
         if (ssd_b !== exp) begin
            miscompares++;
            $display("FAIL %s d%0d lat2: Ssd=%h required %h ('%c')", name, d, ssd_b, exp, ch);
         end
         vectors++;
         if ({an_b, dp_a, dp_b} !== {mask, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL %s d%0d an/dp: An_b=%h Dp=%b/%b required %h 1 1", name, d, an_b, dp_a, dp_b, mask);
         end
      end
      vectors++;
      if (rd_pulses_a - pa != (ok ? 1 : 0) || rd_pulses_b - pb != (ok ? 1 : 0)) begin
         miscompares++;
         $display("FAIL %s rd_en pulses: %0d/%0d required %0d", name, rd_pulses_a - pa,
                  rd_pulses_b - pb, ok ? 1 : 0);
      end
      if (ok) begin
         vectors++;
         if (last_addr_a !== 7'(int'(r) * 9 + int'(c)) || last_addr_b !== 7'(int'(r) * 9 + int'(c))) begin
            miscompares++;
            $display("FAIL %s rd_addr: %0d/%0d required %0d", name, last_addr_a, last_addr_b,
                     int'(r) * 9 + int'(c));
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge Clk);
      #1;
      check_quiet("reset_held", 2);
      Reset = 1'b0;
      check_quiet("after_release", 30);
   endtask

   task automatic test_main;
      board[21] = 4'd5;
      check_frame("main_r2c3", 4'd2, 4'd3, 5'b00010);
      board[0] = 4'd9;
      check_frame("corner_r0c0", 4'd0, 4'd0, 5'b00001);
      board[80] = 4'd1;
      check_frame("corner_r8c8", 4'd8, 4'd8, 5'b00100);
   endtask

   task automatic test_out_of_range;
      check_frame("oor_row9", 4'd9, 4'd0, 5'b00010);
      check_frame("oor_col9", 4'd0, 4'd9, 5'b00100);
      check_frame("oor_both", 4'd15, 4'd15, 5'b00001);
      board[30] = 4'd6;
      check_frame("oor_recover", 4'd3, 4'd3, 5'b00001);
   endtask

   task automatic test_blink;
      board[40] = 4'd0;
      for (int i = 0; i < 4; i++) check_frame("blink_solve", 4'd4, 4'd4, 5'b00010);
      for (int i = 0; i < 3; i++) check_frame("blink_check", 4'd4, 4'd4, 5'b00100);
   endtask

   task automatic test_status;
      board[12] = 4'd12;
      check_frame("status_correct", 4'd1, 4'd3, 5'b01000);
      check_frame("status_incorrect", 4'd1, 4'd3, 5'b10000);
      check_frame("status_multi", 4'd1, 4'd3, 5'b00011);
      check_frame("status_zero", 4'd1, 4'd3, 5'b00000);
   endtask

   task automatic test_latency2;
      junk_b = 4'd7; board[10] = 4'd8;
      check_frame("late_data_8", 4'd1, 4'd1, 5'b00001);
      junk_b = 4'd8; board[10] = 4'd7;
      check_frame("late_data_7", 4'd1, 4'd1, 5'b00001);
   endtask

   task automatic test_random;
      logic [3:0] r, c;
      logic [4:0] st;
      for (int i = 0; i < 12; i++) begin
         r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         c = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         if ($urandom_range(0, 4) == 0) st = 5'($urandom);
         else st = 5'(1 << $urandom_range(0, 4));
         if (r <= 8 && c <= 8) board[int'(r) * 9 + int'(c)] = 4'($urandom_range(0, 15));
         junk_b = 4'($urandom);
         check_frame("random", r, c, st);
      end
   endtask

   task automatic test_reset_mid_req;
      int n;
      board[51] = 4'd4;
      check_frame("pre_reset_r5c6", 4'd5, 4'd6, 5'b00010);
      n = 0;
      do begin
         @(negedge Clk); #1;
         n++;
      end while (en_a !== 1'b1 && n < 200);
      if (en_a !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL reset_mid_req: timeout waiting for rd_en, last en=%b", en_a);
      end
      Reset = 1'b1;
      #1;
      vectors++;
      if ({en_a, en_b, an_a, an_b, ssd_a, addr_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF, 7'h7F, 7'd0}) begin
         miscompares++;
         $display("FAIL reset_mid_req: en=%b/%b An=%h/%h Ssd=%h addr=%0d required 0 0 FF FF 7F 0",
                  en_a, en_b, an_a, an_b, ssd_a, addr_a);
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      check_quiet("after_mid_reset", 30);
      board[21] = 4'd3;
      check_frame("recover_r2c3", 4'd2, 4'd3, 5'b00010);
   endtask

   initial begin
      Reset  = 1'b1;
      row    = 4'd0;
      col    = 4'd0;
      status = 5'b00010;
      junk_b = 4'd0;
      for (int i = 0; i < 81; i++) board[i] = 4'($urandom_range(1, 9));
      test_reset;
      test_main;
      test_out_of_range;
      test_blink;
      test_status;
      test_latency2;
      test_random;
      test_reset_mid_req;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sindoku_board_display.md
Name: sindoku_board_display

Overview:
- Read-side companion of the Sudoku game FSM, which writes board cells.
- Once per display frame, reads the board cell under the cursor through a synchronous read port.
- Shows cursor row, cursor column, cell value and game status on the Nexys-4 8-digit multiplexed seven-segment display.
- Sits between the game FSM / board storage and the board pins.

Parameters:
DIGIT_PERIOD, 100000, clock cycles each digit is lit (minimum 4).
BLINK_FRAMES, 64, frames per blink half-period for an empty cell.
READ_LATENCY, 1, cycles from read enable to valid data (1 or 2).

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
row  input  4  cursor row, 0..8
col  input  4  cursor column, 0..8
status  input  5  game state, one-hot {INCORRECT, CORRECT, CHECK, SOLVE, I}
cell_rd_en  output  1  one-cycle read strobe
cell_rd_addr  output  7  linear cell address, row*9+col
cell_rd_data  input  4  cell value 0..9; 0 means empty
An  output  8  digit anodes, active-low
Ssd  output  7  segments {g..a}, active-low
Dp  output  1  decimal point, active-low; held 1

Behaviour:
- Interface: one clock (Clk); reset (Reset) is asynchronous and active-high.
- Reset values: An=8'hFF, Ssd=7'h7F, Dp=1, cell_rd_en=0, cell_rd_addr=0; refresh counter, digit index, blink counter, latched value = 0; blink phase = on; FSM = IDLE.
- Reset mid-read: cell_rd_en drops immediately, and any data still in flight is discarded.
- Refresh counter counts 0..DIGIT_PERIOD-1. When it wraps, digit index advances 0..7 and wraps 7 to 0.
- An drives low only the bit at the current digit index. Ssd is registered, so it is valid in the same cycle An changes.
- Frame start is the cycle the digit index wraps to 0. On frame start, row/col are sampled into row_s/col_s, and the blink counter increments.
- Blink phase toggles when the blink counter reaches BLINK_FRAMES-1; the counter then clears.
- Read FSM:
  - IDLE: on frame start, go to REQ if row_s<=8 and col_s<=8. Otherwise set the invalid flag and stay in IDLE.
  - REQ: cell_rd_en=1 for exactly one cycle with cell_rd_addr=row_s*9+col_s; go to WAIT.
  - WAIT: hold READ_LATENCY cycles. On the last cycle, latch cell_rd_data, clear the invalid flag, go to IDLE.
- cell_rd_addr holds its last value outside REQ. Cursor changes mid-frame are not observed until the next frame.
- Digit map, digit 7 leftmost:
  - d7 = 'r', d6 = row_s+1.
  - d5 = 'c', d4 = col_s+1.
  - d3 blank.
  - d2 = latched value.
  - d1 blank.
  - d0 = status glyph: I -> 'I', SOLVE -> 'S', CHECK -> 'C', CORRECT -> 'P', INCORRECT -> 'F'.
- Out-of-range cursor: row_s>8 shows '-' on d6 and d2; col_s>8 shows '-' on d4 and d2.
- Status not exactly one-hot (zero or multiple bits): d0 shows '-'.
- Empty cell (latched value 0): d2 shows '_'. If status=SOLVE as well, d2 is blank while blink phase is off.
- Latched value >9: d2 shows 'E'.
- Simultaneous frame start while not in IDLE (impossible for DIGIT_PERIOD>=4): frame start is ignored and no new read is issued.

Decomposition:
- Package sindoku_pkg:
  - BOARD_DIM=9
  - one-hot state constants I/SOLVE/CHECK/CORRECT/INCORRECT
  - glyph code constants: digits 0-9, r, c, I, S, C, P, F, '-', '_', E, blank
  - 7-bit active-low segment patterns
- One sub-module, sindoku_glyph: combinational glyph code -> Ssd pattern.

Test Plan:
- Reset asserted mid-REQ -> cell_rd_en=0 and An=8'hFF the same cycle; all outputs at reset values until the first frame after release.
- DIGIT_PERIOD=4, row=2, col=3, data=5 -> one rd_en pulse, addr=21 per frame; digits show r 3 c 4 _ 5 _ S with status=SOLVE.
- row=9, col=0 -> no rd_en all frame; d6 and d2 show '-'; other digits unaffected.
- data=0, status=SOLVE, BLINK_FRAMES=2 -> d2 alternates '_'/blank every 2 frames; with status=CHECK, d2 is steady '_'.
- status=5'b01000 -> d0 'P'; 5'b10000 -> 'F'; 5'b00011 -> '-'.
- READ_LATENCY=2, data changed from 7 to 8 one cycle after rd_en -> value latched at second WAIT cycle, display shows 8.
